// File: rtl/lsu.sv
// Load-store unit for the single-cycle RV32I core.
// Holds the data memory and the memory-mapped I/O registers. Stores commit
// on the rising clock edge, and loads return combinationally in the same cycle.
module lsu #(
  parameter int DMEM_WORDS  = 2048,
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic        i_lsu_wren,
  input  logic [2:0]  i_lsu_op,
  output logic [31:0] o_ld_data,
  output logic        o_misaligned,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [55:0] o_io_hex,
  output logic [31:0] o_io_lcd,
  input  logic [31:0] i_io_sw,
  input  logic [3:0]  i_io_btn
);

  localparam int IDX_W = $clog2(DMEM_WORDS);

  logic [31:0]      dmem [DMEM_WORDS];
  logic [IDX_W-1:0] dmem_idx;

  logic [31:0] ledr_q, ledg_q, lcd_q, hex_lo_q, hex_hi_q;
  logic [31:0] sw_sync  [SYNC_STAGES];
  logic [3:0]  btn_sync [SYNC_STAGES];

  logic hit_dmem, hit_ledr, hit_ledg, hit_hex_lo, hit_hex_hi, hit_lcd;
  logic hit_sw, hit_btn;

  logic        op_valid;
  logic        misaligned;
  logic        access_ok;
  logic        st_en;
  logic [3:0]  byte_en;
  logic [31:0] wdata;
  logic [31:0] rd_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Region decode looks only at the upper address bits; DMEM spans 0x2000-0x3FFF.
  assign hit_dmem   = (i_lsu_addr[31:13] == 19'h00001);
  assign hit_ledr   = (i_lsu_addr[31:12] == 20'h10000);
  assign hit_ledg   = (i_lsu_addr[31:12] == 20'h10001);
  assign hit_hex_lo = (i_lsu_addr[31:12] == 20'h10002);
  assign hit_hex_hi = (i_lsu_addr[31:12] == 20'h10003);
  assign hit_lcd    = (i_lsu_addr[31:12] == 20'h10004);
  assign hit_sw     = (i_lsu_addr[31:12] == 20'h10010);
  assign hit_btn    = (i_lsu_addr[31:12] == 20'h10011);

  assign dmem_idx = i_lsu_addr[IDX_W+1:2];

  // Decode the access width into legality, alignment and little-endian byte lanes.
  always_comb begin
    op_valid   = 1'b0;
    misaligned = 1'b0;
    byte_en    = 4'b0000;
    case (i_lsu_op)
      3'b000, 3'b100: begin
        op_valid = 1'b1;
        byte_en  = 4'b0001 << i_lsu_addr[1:0];
      end
      3'b001, 3'b101: begin
        op_valid   = 1'b1;
        misaligned = i_lsu_addr[0];
        byte_en    = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
      end
      3'b010: begin
        op_valid   = 1'b1;
        misaligned = |i_lsu_addr[1:0];
        byte_en    = 4'b1111;
      end
      default: begin
        op_valid = 1'b0;
      end
    endcase
  end

  assign o_misaligned = misaligned;
  assign access_ok    = op_valid & ~misaligned;
  assign st_en        = i_rst_n & i_lsu_wren & access_ok;

  // Replicate store data so that every enabled lane sees its byte in place.
  always_comb begin
    wdata = i_st_data;
    case (i_lsu_op[1:0])
      2'b00:   wdata = {4{i_st_data[7:0]}};
      2'b01:   wdata = {2{i_st_data[15:0]}};
      default: wdata = i_st_data;
    endcase
  end

  // Data memory write port, byte-lane granular; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (st_en && hit_dmem) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) dmem[dmem_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Writable I/O registers; HEX bytes keep only the 7 segment bits.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ledr_q   <= '0;
      ledg_q   <= '0;
      lcd_q    <= '0;
      hex_lo_q <= 32'h7F7F7F7F;
      hex_hi_q <= 32'h7F7F7F7F;
    end else if (st_en) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          if (hit_ledr)   ledr_q[8*b +: 8]   <= wdata[8*b +: 8];
          if (hit_ledg)   ledg_q[8*b +: 8]   <= wdata[8*b +: 8];
          if (hit_lcd)    lcd_q[8*b +: 8]    <= wdata[8*b +: 8];
          if (hit_hex_lo) hex_lo_q[8*b +: 8] <= {1'b0, wdata[8*b +: 7]};
          if (hit_hex_hi) hex_hi_q[8*b +: 8] <= {1'b0, wdata[8*b +: 7]};
        end
      end
    end
  end

  // Switch and button synchronizer chains; loads see only the last stage.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sw_sync[i]  <= '0;
        btn_sync[i] <= '0;
      end
    end else begin
      sw_sync[0]  <= i_io_sw;
      btn_sync[0] <= i_io_btn;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sw_sync[i]  <= sw_sync[i-1];
        btn_sync[i] <= btn_sync[i-1];
      end
    end
  end

  // Select the addressed word; unmapped regions read as zero.
  always_comb begin
    rd_word = '0;
    if (hit_dmem)        rd_word = dmem[dmem_idx];
    else if (hit_ledr)   rd_word = ledr_q;
    else if (hit_ledg)   rd_word = ledg_q;
    else if (hit_hex_lo) rd_word = hex_lo_q;
    else if (hit_hex_hi) rd_word = hex_hi_q;
    else if (hit_lcd)    rd_word = lcd_q;
    else if (hit_sw)     rd_word = sw_sync[SYNC_STAGES-1];
    else if (hit_btn)    rd_word = {28'd0, btn_sync[SYNC_STAGES-1]};
  end

  assign ld_byte = rd_word[{i_lsu_addr[1:0], 3'b000} +: 8];
  assign ld_half = i_lsu_addr[1] ? rd_word[31:16] : rd_word[15:0];

  // Extract and extend the load lane; illegal or misaligned accesses read zero.
  always_comb begin
    o_ld_data = '0;
    if (access_ok) begin
      case (i_lsu_op)
        3'b000:  o_ld_data = {{24{ld_byte[7]}}, ld_byte};
        3'b100:  o_ld_data = {24'd0, ld_byte};
        3'b001:  o_ld_data = {{16{ld_half[15]}}, ld_half};
        3'b101:  o_ld_data = {16'd0, ld_half};
        3'b010:  o_ld_data = rd_word;
        default: o_ld_data = '0;
      endcase
    end
  end

  // Pack the seven-segment digits, HEX0 in the least significant bits.
  always_comb begin
    o_io_hex = '0;
    for (int k = 0; k < 4; k++) begin
      o_io_hex[7*k +: 7]     = hex_lo_q[8*k +: 7];
      o_io_hex[7*(k+4) +: 7] = hex_hi_q[8*k +: 7];
    end
  end

  assign o_io_ledr = ledr_q;
  assign o_io_ledg = ledg_q;
  assign o_io_lcd  = lcd_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for the load-store unit: a vector table plus
// hand-written sequences for reset, HEX masking and synchronizer latency.
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic [31:0] lsu_addr;
  logic [31:0] st_data;
  logic        lsu_wren;
  logic [2:0]  lsu_op;
  logic [31:0] ld_data;
  logic        misaligned;
  logic [31:0] io_ledr, io_ledg, io_lcd, io_sw;
  logic [55:0] io_hex;
  logic [3:0]  io_btn;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        wren;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic        chk;
    logic [31:0] ld;
    logic        mis;
    string       name;
  } vec_t;

  typedef struct {
    logic        chk;
    logic [31:0] ld;
    logic        mis;
  } exp_t;

  vec_t  vecs[$];
  exp_t  sb[$];
  string sb_name[$];

  lsu #(.DMEM_WORDS(2048), .SYNC_STAGES(2)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_lsu_addr   (lsu_addr),
    .i_st_data    (st_data),
    .i_lsu_wren   (lsu_wren),
    .i_lsu_op     (lsu_op),
    .o_ld_data    (ld_data),
    .o_misaligned (misaligned),
    .o_io_ledr    (io_ledr),
    .o_io_ledg    (io_ledg),
    .o_io_hex     (io_hex),
    .o_io_lcd     (io_lcd),
    .i_io_sw      (io_sw),
    .i_io_btn     (io_btn)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic w, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] d, input logic c, input logic [31:0] ld,
                        input logic mis, input string name);
    vec_t v;
    v.wren = w; v.op = op; v.addr = a; v.data = d;
    v.chk = c; v.ld = ld; v.mis = mis; v.name = name;
    vecs.push_back(v);
  endtask

  // Drive one access on the falling edge and queue what the DUT should return.
  task automatic applyStimulus(input logic rst, input logic w, input logic [2:0] op,
                               input logic [31:0] a, input logic [31:0] d, input logic c,
                               input logic [31:0] ld, input logic mis, input string name);
    exp_t e;
    @(negedge clk);
    rst_n    = rst;
    lsu_wren = w;
    lsu_op   = op;
    lsu_addr = a;
    st_data  = d;
    e.chk = c; e.ld = ld; e.mis = mis;
    sb.push_back(e);
    sb_name.push_back(name);
  endtask

  // Pop the oldest expectation and compare it with the combinational outputs.
  task automatic checkOutput();
    exp_t  e;
    string n;
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: queue empty, got nothing expected an entry");
    end else begin
      e = sb.pop_front();
      n = sb_name.pop_front();
      checkVal({n, "_mis"}, {63'd0, misaligned}, {63'd0, e.mis});
      if (e.chk) checkVal({n, "_ld"}, {32'd0, ld_data}, {32'd0, e.ld});
    end
  endtask

  initial begin
    rst_n = 1'b0; lsu_wren = 1'b0; lsu_op = 3'b010;
    lsu_addr = '0; st_data = '0; io_sw = '0; io_btn = '0;

    addVec(1, 3'b010, 32'h0000_2004, 32'hDEADBEEF, 0, 32'h0,        0, "sw_word");
    addVec(0, 3'b010, 32'h0000_2004, 32'h0,        1, 32'hDEADBEEF, 0, "lw_word");
    addVec(1, 3'b010, 32'h0000_2008, 32'h11223344, 0, 32'h0,        0, "sw_base");
    addVec(0, 3'b010, 32'h0000_2008, 32'h0,        1, 32'h11223344, 0, "lw_base");
    addVec(1, 3'b000, 32'h0000_2009, 32'h00000080, 1, 32'h00000033, 0, "sb_prewrite");
    addVec(0, 3'b010, 32'h0000_2008, 32'h0,        1, 32'h11228044, 0, "lw_after_sb");
    addVec(0, 3'b000, 32'h0000_2009, 32'h0,        1, 32'hFFFFFF80, 0, "lb_sign");
    addVec(0, 3'b100, 32'h0000_2009, 32'h0,        1, 32'h00000080, 0, "lbu_zero");
    addVec(0, 3'b001, 32'h0000_2008, 32'h0,        1, 32'hFFFF8044, 0, "lh_sign");
    addVec(0, 3'b101, 32'h0000_200A, 32'h0,        1, 32'h00001122, 0, "lhu_upper");
    addVec(1, 3'b010, 32'h0000_2000, 32'h00000000, 0, 32'h0,        0, "sw_clear");
    addVec(1, 3'b001, 32'h0000_2002, 32'h0000ABCD, 1, 32'h00000000, 0, "sh_upper");
    addVec(0, 3'b101, 32'h0000_2002, 32'h0,        1, 32'h0000ABCD, 0, "lhu_after_sh");
    addVec(0, 3'b010, 32'h0000_2002, 32'h0,        1, 32'h00000000, 1, "lw_misaligned");
    addVec(0, 3'b010, 32'h0000_2000, 32'h0,        1, 32'hABCD0000, 0, "lw_after_sh");
    addVec(1, 3'b010, 32'h0000_2001, 32'hFFFFFFFF, 1, 32'h00000000, 1, "sw_misaligned");
    addVec(0, 3'b010, 32'h0000_2000, 32'h0,        1, 32'hABCD0000, 0, "mem_unchanged");
    addVec(0, 3'b001, 32'h0000_2001, 32'h0,        1, 32'h00000000, 1, "lh_misaligned");
    addVec(0, 3'b010, 32'h0000_5000, 32'h0,        1, 32'h00000000, 0, "lw_unmapped");
    addVec(1, 3'b111, 32'h0000_2000, 32'h12345678, 1, 32'h00000000, 0, "st_op111");
    addVec(0, 3'b010, 32'h0000_2000, 32'h0,        1, 32'hABCD0000, 0, "op111_nochange");
    addVec(0, 3'b011, 32'h0000_2001, 32'h0,        1, 32'h00000000, 0, "ld_op011");
    addVec(0, 3'b000, 32'h0000_2003, 32'h0,        1, 32'hFFFFFFAB, 0, "lb_lane3");
    addVec(0, 3'b100, 32'h0000_2002, 32'h0,        1, 32'h000000CD, 0, "lbu_lane2");
    addVec(1, 3'b010, 32'h1000_0000, 32'h000000FF, 1, 32'h00000000, 0, "sw_ledr");
    addVec(0, 3'b010, 32'h1000_0000, 32'h0,        1, 32'h000000FF, 0, "lw_ledr");
    addVec(1, 3'b010, 32'h0000_3FFC, 32'hCAFEF00D, 0, 32'h0,        0, "sw_top");
    addVec(0, 3'b010, 32'h0000_3FFC, 32'h0,        1, 32'hCAFEF00D, 0, "lw_top");
    addVec(0, 3'b010, 32'h0000_4000, 32'h0,        1, 32'h00000000, 0, "lw_above");
    addVec(0, 3'b010, 32'h0000_1FFC, 32'h0,        1, 32'h00000000, 0, "lw_below");
    addVec(1, 3'b010, 32'h0000_4000, 32'h00000077, 1, 32'h00000000, 0, "sw_above");
    addVec(0, 3'b010, 32'h0000_2000, 32'h0,        1, 32'hABCD0000, 0, "no_alias");
    addVec(1, 3'b010, 32'h1000_1000, 32'h12345678, 1, 32'h00000000, 0, "sw_ledg");
    addVec(0, 3'b010, 32'h1000_1000, 32'h0,        1, 32'h12345678, 0, "lw_ledg");
    addVec(1, 3'b001, 32'h1000_4002, 32'h0000BEEF, 1, 32'h00000000, 0, "sh_lcd");
    addVec(0, 3'b010, 32'h1000_4000, 32'h0,        1, 32'hBEEF0000, 0, "lw_lcd");

    // Reset state
    applyStimulus(0, 0, 3'b010, 32'h0, 32'h0, 0, 32'h0, 0, "rst0"); checkOutput();
    applyStimulus(0, 0, 3'b010, 32'h0, 32'h0, 0, 32'h0, 0, "rst1"); checkOutput();
    applyStimulus(1, 0, 3'b010, 32'h1000_2000, 32'h0, 1, 32'h7F7F7F7F, 0, "hex_rst_rd");
    checkOutput();
    checkVal("ledr_rst", {32'd0, io_ledr}, 64'd0);
    checkVal("ledg_rst", {32'd0, io_ledg}, 64'd0);
    checkVal("lcd_rst",  {32'd0, io_lcd},  64'd0);
    checkVal("hex_rst",  {8'd0, io_hex},   {8'd0, 56'hFF_FFFF_FFFF_FFFF});

    // Vector table
    foreach (vecs[i]) begin
      applyStimulus(1, vecs[i].wren, vecs[i].op, vecs[i].addr, vecs[i].data,
                    vecs[i].chk, vecs[i].ld, vecs[i].mis, vecs[i].name);
      checkOutput();
    end
    checkVal("ledr_out", {32'd0, io_ledr}, 64'h0000_00FF);
    checkVal("ledg_out", {32'd0, io_ledg}, 64'h1234_5678);
    checkVal("lcd_out",  {32'd0, io_lcd},  64'hBEEF_0000);

    // HEX bit-7 masking and digit packing
    applyStimulus(1, 1, 3'b000, 32'h1000_2001, 32'h000000C0, 1, 32'h0000007F, 0, "sb_hex1");
    checkOutput();
    applyStimulus(1, 0, 3'b100, 32'h1000_2001, 32'h0, 1, 32'h00000040, 0, "lbu_hex1");
    checkOutput();
    checkVal("hex_digit1", {8'd0, io_hex}, {8'd0, 56'hFF_FFFF_FFFF_E07F});
    applyStimulus(1, 0, 3'b010, 32'h1000_2000, 32'h0, 1, 32'h7F7F407F, 0, "lw_hex_lo");
    checkOutput();
    applyStimulus(1, 1, 3'b010, 32'h1000_3000, 32'h81828384, 1, 32'h7F7F7F7F, 0, "sw_hex_hi");
    checkOutput();
    applyStimulus(1, 0, 3'b010, 32'h1000_3000, 32'h0, 1, 32'h01020304, 0, "lw_hex_hi");
    checkOutput();
    checkVal("hex_upper", {36'd0, io_hex[55:28]}, {36'd0, 7'h01, 7'h02, 7'h03, 7'h04});

    // Reset beats simultaneous stores; DMEM keeps its contents
    applyStimulus(0, 1, 3'b010, 32'h1000_0000, 32'h55555555, 0, 32'h0, 0, "rst_st_io");
    checkOutput();
    applyStimulus(0, 1, 3'b010, 32'h0000_2004, 32'h00000000, 0, 32'h0, 0, "rst_st_mem");
    checkOutput();
    applyStimulus(1, 0, 3'b010, 32'h0000_2004, 32'h0, 1, 32'hDEADBEEF, 0, "mem_keep");
    checkOutput();
    checkVal("ledr_after_rst", {32'd0, io_ledr}, 64'd0);
    checkVal("lcd_after_rst",  {32'd0, io_lcd},  64'd0);
    checkVal("hex_after_rst",  {8'd0, io_hex},   {8'd0, 56'hFF_FFFF_FFFF_FFFF});

    // Synchronizer latency and read-only ports
    applyStimulus(1, 0, 3'b010, 32'h1001_0000, 32'h0, 1, 32'h0, 0, "sw_edge0");
    checkOutput();
    io_sw  = 32'h0000_0005;
    io_btn = 4'hA;
    applyStimulus(1, 0, 3'b010, 32'h1001_0000, 32'h0, 1, 32'h0, 0, "sw_edge1");
    checkOutput();
    applyStimulus(1, 0, 3'b010, 32'h1001_0000, 32'h0, 1, 32'h5, 0, "sw_edge2");
    checkOutput();
    applyStimulus(1, 0, 3'b010, 32'h1001_1000, 32'h0, 1, 32'hA, 0, "btn_read");
    checkOutput();
    applyStimulus(1, 1, 3'b010, 32'h1001_0000, 32'hFFFFFFFF, 1, 32'h5, 0, "sw_store");
    checkOutput();
    applyStimulus(1, 0, 3'b010, 32'h1001_0000, 32'h0, 1, 32'h5, 0, "sw_ro");
    checkOutput();
    applyStimulus(1, 1, 3'b010, 32'h1001_1000, 32'h0000000F, 1, 32'hA, 0, "btn_store");
    checkOutput();
    applyStimulus(1, 0, 3'b010, 32'h1001_1000, 32'h0, 1, 32'hA, 0, "btn_ro");
    checkOutput();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
